serial_subtractor: RTL and testbench

Bit-serial, LSB-first unsigned subtractor that computes diff = a - b for WIDTH-bit operands. It feeds one bit pair per clock, plus the registered borrow, into a single one-bit full-subtractor cell. The block sits directly upstream of that cell and consumes its Diff/Bout outputs. It trades WIDTH cycles of latency for a single subtractor cell; the result is presented with a start/done handshake.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_fs_cell.sv | 14 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
// Counter sizing helper lets every instance derive its own bit-index width from WIDTH.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Never return less than one bit, so the counter stays a legal vector at small widths.
   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full subtractor: diff = a - b - bin, with the borrow out.
// Purely combinational, zero latency, no flow control.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial subtractor: WIDTH cycles through one fs_cell, result pulsed on done.
// Latency WIDTH+1 edges from start to done; start is dropped (not queued) while busy.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] d_sh_q, d_sh_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_out_q, borrow_out_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic             cell_diff;
   logic             cell_bout;
   logic [WIDTH-1:0] res_word;

   fs_cell u_cell (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (borrow_q),
      .diff (cell_diff),
      .bout (cell_bout)
   );

   // d_sh only needs the upper WIDTH-1 bits; the newest bit comes straight from the cell.
   assign res_word = {cell_diff, d_sh_q};

   always_comb begin
      state_d      = state_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      d_sh_d       = d_sh_q;
      borrow_d     = borrow_q;
      cnt_d        = cnt_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               d_sh_d   = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            d_sh_d   = res_word[WIDTH-1:1];
            borrow_d = cell_bout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               diff_d       = res_word;
               borrow_out_d = cell_bout;
               state_d      = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         d_sh_q       <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         d_sh_q       <= d_sh_d;
         borrow_q     <= borrow_d;
         cnt_q        <= cnt_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for protocol cases, a 4-bit one for an exhaustive sweep.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bo8;
   logic [7:0] diff8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, bo4;
   logic [3:0] diff4;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation from IDLE; checks latency, result and the busy drop.
   task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] exp_d, input logic exp_bo);
      int lat;
      lat = 0;
      start8 = 1'b1; a8 = av; b8 = bv;
      tick();
      start8 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (done8) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_latency"}, lat, 8);
      chk({tag, "_diff"}, diff8, exp_d);
      chk({tag, "_borrow"}, bo8, exp_bo);
      chk({tag, "_busy_at_done"}, busy8, 1);
      tick();
      chk({tag, "_done_pulse"}, done8, 0);
      chk({tag, "_busy_after"}, busy8, 0);
   endtask

   initial begin
      int dones;
      int bad_phase;
      int seen;
      logic [4:0] ref4;

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_diff", diff8, 0);
      chk("rst_borrow", bo8, 0);
      rst_n = 1'b1;
      tick();

      // Basic vectors
      op8("op_200_55", 8'd200, 8'd55, 8'h91, 1'b0);
      op8("op_5_9", 8'd5, 8'd9, 8'hFC, 1'b1);
      op8("op_0_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
      op8("op_a5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0);
      op8("op_ff_0", 8'hFF, 8'h00, 8'hFF, 1'b0);

      // start re-asserted during RUN and DONE must be dropped
      start8 = 1'b1; a8 = 8'd10; b8 = 8'd3;
      tick();
      a8 = 8'd0; b8 = 8'd1;
      dones = 0;
      for (int e = 1; e <= 22; e++) begin
         start8 = (e == 3 || e == 8 || e == 9);
         tick();
         if (done8) dones++;
         if (e == 8) begin
            chk("ign_done_edge8", done8, 1);
            chk("ign_diff", diff8, 7);
            chk("ign_borrow", bo8, 0);
         end
      end
      start8 = 1'b0;
      chk("ign_single_done", dones, 1);
      chk("ign_idle", busy8, 0);

      // Reset mid-RUN abandons the operation and clears the result
      start8 = 1'b1; a8 = 8'd100; b8 = 8'd1;
      tick();
      start8 = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_busy", busy8, 0);
      chk("mid_rst_diff", diff8, 0);
      chk("mid_rst_borrow", bo8, 0);
      dones = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         if (done8) dones++;
      end
      chk("mid_rst_no_done", dones, 0);
      op8("after_rst", 8'd100, 8'd1, 8'd99, 1'b0);

      // Back-to-back with start held high: one acceptance every WIDTH+2 edges
      start8 = 1'b1; a8 = 8'd7; b8 = 8'd2;
      dones = 0;
      bad_phase = 0;
      for (int e = 0; e <= 30; e++) begin
         tick();
         if (done8) begin
            dones++;
            if (e % 10 != 8) bad_phase++;
            chk("b2b_diff", diff8, 5);
            chk("b2b_borrow", bo8, 0);
         end
      end
      start8 = 1'b0;
      chk("b2b_done_count", dones, 3);
      chk("b2b_spacing", bad_phase, 0);
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (!busy8) begin
            seen = 1;
            break;
         end
      end
      chk("b2b_drain", seen, 1);

      // Exhaustive 4-bit sweep
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            start4 = 1'b1; a4 = 4'(i); b4 = 4'(j);
            tick();
            start4 = 1'b0;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
               tick();
               if (done4) begin
                  seen = 1;
                  break;
               end
            end
            ref4 = {1'b0, 4'(i)} - {1'b0, 4'(j)};
            if (seen == 0) chk("sweep_timeout", seen, 1);
            chk($sformatf("sweep_diff_%0d_%0d", i, j), diff4, ref4[3:0]);
            chk($sformatf("sweep_borrow_%0d_%0d", i, j), bo4, (i < j) ? 1 : 0);
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
